// File: rtl/clk_div_ctrl_pkg.sv
// Shared constants and FSM encoding for the board clock divider controller.
package clk_div_ctrl_pkg;

    localparam int unsigned DIV_W_DEF        = 32;
    localparam int unsigned DEFAULT_HALF_DEF = 50000;  // 500 Hz from a 50 MHz clk_in
    localparam int unsigned MIN_HALF_DEF     = 2;

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUN     = 2'd1,
        ST_DRAIN   = 2'd2
    } state_e;

endpackage

// File: rtl/clk_div_core.sv
// Divide counter: owns the half-period, the count, the divided clock and its rise tick.
module clk_div_core
    import clk_div_ctrl_pkg::*;
#(
    parameter int unsigned DIV_W        = DIV_W_DEF,
    parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             run,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    output logic             clk_out,
    output logic             tick,
    output logic             period_end_c
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] half_q, half_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             wrap_c;

    // Count 0..half-1 while running; a stopped core parks at cnt=0 with clk_out low.
    always_comb begin
        cnt_d        = '0;
        clk_out_d    = 1'b0;
        tick_d       = 1'b0;
        half_d       = load ? load_val : half_q;
        wrap_c       = (cnt_q == half_q - DIV_W'(1));
        period_end_c = run & clk_out_q & wrap_c;
        if (run) begin
            if (wrap_c) begin
                clk_out_d = ~clk_out_q;
                tick_d    = ~clk_out_q;
            end else begin
                cnt_d     = cnt_q + DIV_W'(1);
                clk_out_d = clk_out_q;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            half_q    <= DIV_W'(DEFAULT_HALF);
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            half_q    <= half_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time clock divider controller: start/stop FSM, shadowed divide ratio and
// valid/ready config port; ratio changes land only on full-period boundaries.
module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int unsigned DIV_W        = DIV_W_DEF,
    parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF,
    parameter int unsigned MIN_HALF     = MIN_HALF_DEF
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_half,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick,
    output logic             running
);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic             cfg_err_q, cfg_err_d;
    logic             running_q, running_d;
    logic             run_c, load_c, xfer_c, period_end_c;

    // cfg_ready low doubles as the "shadow pending" flag.
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        cfg_ready_d = cfg_ready_q;
        cfg_err_d   = 1'b0;
        load_c      = 1'b0;
        run_c       = (state_q != ST_STOPPED);
        xfer_c      = cfg_valid & cfg_ready_q;

        case (state_q)
            ST_STOPPED: if (enable) state_d = ST_RUN;
            ST_RUN:     if (!enable) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (enable)            state_d = ST_RUN;
                else if (period_end_c) state_d = ST_STOPPED;
            end
            default:    state_d = ST_STOPPED;
        endcase

        if (!cfg_ready_q && (!run_c || period_end_c)) begin
            load_c      = 1'b1;
            cfg_ready_d = 1'b1;
        end

        // A transfer can only happen with nothing pending, so it never races the load.
        if (xfer_c) begin
            if (cfg_half < DIV_W'(MIN_HALF)) begin
                cfg_err_d = 1'b1;
            end else begin
                shadow_d    = cfg_half;
                cfg_ready_d = 1'b0;
            end
        end

        running_d = (state_d != ST_STOPPED);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_STOPPED;
            shadow_q    <= '0;
            cfg_ready_q <= 1'b1;
            cfg_err_q   <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            cfg_ready_q <= cfg_ready_d;
            cfg_err_q   <= cfg_err_d;
            running_q   <= running_d;
        end
    end

    clk_div_core #(
        .DIV_W        (DIV_W),
        .DEFAULT_HALF (DEFAULT_HALF)
    ) u_core (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .run          (run_c),
        .load         (load_c),
        .load_val     (shadow_q),
        .clk_out      (clk_out),
        .tick         (tick),
        .period_end_c (period_end_c)
    );

    assign cfg_ready = cfg_ready_q;
    assign cfg_err   = cfg_err_q;
    assign running   = running_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: a period-position reference model predicts every
// cycle's outputs; a negedge monitor pops and compares them against the DUT.
module tb_clk_div_ctrl;

    localparam int unsigned DIV_W = 32;
    localparam int          HALF0 = 5;
    localparam int          MINH  = 2;

    logic             clk_in = 1'b0;
    logic             rst_n;
    logic             enable;
    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_half;
    logic             cfg_ready, cfg_err, clk_out, tick, running;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic clk;
        logic tck;
        logic run;
        logic rdy;
        logic err;
    } exp_t;

    exp_t exp_q[$];

    clk_div_ctrl #(
        .DIV_W        (DIV_W),
        .DEFAULT_HALF (HALF0),
        .MIN_HALF     (MINH)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .enable    (enable),
        .cfg_valid (cfg_valid),
        .cfg_half  (cfg_half),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick      (tick),
        .running   (running)
    );

    always #10 clk_in = ~clk_in;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0=stopped 1=running 2=draining; pos = place in the
    // 2*h-cycle period, clk_out high for pos in [h, 2h).
    int   m_mode, m_pos, m_h, m_shadow;
    bit   m_pend, m_oldpend, m_fire, m_end;
    int   m_nmode, m_npos;
    logic m_tick, m_err;

    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            m_mode   = 0;
            m_pos    = 0;
            m_h      = HALF0;
            m_shadow = 0;
            m_pend   = 0;
            exp_q.delete();
        end else begin
            m_oldpend = m_pend;
            m_fire    = cfg_valid && !m_oldpend;
            m_end     = (m_mode != 0) && (m_pos == 2 * m_h - 1);
            m_tick    = (m_mode != 0) && (m_pos == m_h - 1);
            m_err     = 1'b0;

            if (m_mode == 0)  m_npos = 0;
            else if (m_end)   m_npos = 0;
            else              m_npos = m_pos + 1;

            case (m_mode)
                0:       m_nmode = enable ? 1 : 0;
                1:       m_nmode = enable ? 1 : 2;
                default: m_nmode = enable ? 1 : (m_end ? 0 : 2);
            endcase

            if (m_oldpend && (m_mode == 0 || m_end)) begin
                m_h    = m_shadow;
                m_pend = 0;
            end
            if (m_fire) begin
                if (cfg_half < 32'(MINH)) m_err = 1'b1;
                else begin
                    m_shadow = int'(cfg_half);
                    m_pend   = 1;
                end
            end

            m_mode = m_nmode;
            m_pos  = m_npos;
            exp_q.push_back('{clk: (m_pos >= m_h), tck: m_tick, run: (m_mode != 0),
                              rdy: !m_pend, err: m_err});
        end
    end

    // Outputs that no clock edge has touched since reset must still hold reset values.
    always @(negedge clk_in) begin
        exp_t e;
        if (!rst_n || exp_q.size() == 0) e = '{clk: 1'b0, tck: 1'b0, run: 1'b0, rdy: 1'b1, err: 1'b0};
        else                             e = exp_q.pop_front();
        check("clk_out",   clk_out,   e.clk);
        check("tick",      tick,      e.tck);
        check("running",   running,   e.run);
        check("cfg_ready", cfg_ready, e.rdy);
        check("cfg_err",   cfg_err,   e.err);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic send(input int v);
        cfg_valid = 1'b1;
        cfg_half  = 32'(v);
        @(negedge clk_in);
        cfg_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        cfg_half  = '0;
        cyc(3);
        rst_n = 1'b1;

        cyc(3);
        enable = 1'b1;
        cyc(40);

        cyc(6);
        send(3);
        cyc(40);

        send(1);
        cyc(30);

        // Sweep the transfer across every offset so some land on a period-end wrap.
        send(5);
        cyc(12);
        for (int off = 0; off < 12; off++) begin
            cyc(off);
            send(2 + off % 4);
            cyc(20);
        end

        enable = 1'b0;
        cyc(30);
        enable = 1'b1;
        cyc(7);
        enable = 1'b0;
        cyc(3);
        enable = 1'b1;
        cyc(20);

        // Stopped with a pending shadow: it must be applied while stopped.
        enable = 1'b0;
        cyc(30);
        send(4);
        cyc(4);
        enable = 1'b1;
        cyc(30);

        // Async reset between edges with an update pending.
        send(7);
        #5 rst_n = 1'b0;
        #2;
        check("rst_clk_out",   clk_out,   1'b0);
        check("rst_running",   running,   1'b0);
        check("rst_tick",      tick,      1'b0);
        check("rst_cfg_ready", cfg_ready, 1'b1);
        check("rst_cfg_err",   cfg_err,   1'b0);
        @(negedge clk_in);
        rst_n = 1'b1;
        cyc(30);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_in);
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_half  = 32'($urandom_range(0, 9));
            if ($urandom_range(0, 24) == 0) enable = ~enable;
        end
        cfg_valid = 1'b0;
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
